// File: rtl/eth_frame_pkg.sv
// Shared types and constants for the Ethernet II frame builder.
// ETH_FRAME_PAD_EN adds the PAD state used for minimum-length padding.
package eth_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_DATA = 3'd2,
`ifdef ETH_FRAME_PAD_EN
    ST_TAIL = 3'd3,
    ST_PAD  = 3'd4
`else
    ST_TAIL = 3'd3
`endif
  } state_e;

  localparam int          ETH_HDR_BYTES         = 14;
  localparam int          ETH_MIN_FRAME_BYTES   = 60;
  localparam int          ETH_MIN_FRAME_WORDS   = 15;
  localparam logic [15:0] ETH_DEFAULT_ETHERTYPE = 16'h8915;
  localparam logic [47:0] ETH_DEFAULT_SRC_MAC   = 48'h000A35010203;

  // Header word idx (0..2) out of {dst, src}, both MSB-first on the wire.
  function automatic logic [31:0] hdr_word(input logic [1:0] idx, input logic [47:0] dst,
                                           input logic [47:0] src);
    logic [95:0] hdr;
    logic [31:0] w;
    int          base;
    hdr  = {dst, src};
    w    = 32'h0;
    base = (idx > 2'd2) ? 8 : 4 * int'(idx);
    for (int b = 0; b < 4; b++) begin
      w[8*b +: 8] = hdr[95 - 8*(base + b) -: 8];
    end
    return w;
  endfunction

  function automatic logic [31:0] keep_mask(input logic [31:0] d, input logic [3:0] k);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = d[8*b +: 8] & {8{k[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/eth_frame_builder_if.sv
// 32-bit AXI-Stream bundle used for both payload input and frame output.
interface eth_frame_builder_if;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/eth_tx_byte_shift.sv
// Two-byte realignment of payload behind the EtherType: carry register plus
// the merge/keep/last logic for the DATA and TAIL beats.
module eth_tx_byte_shift
  import eth_frame_pkg::*;
#(
  parameter logic [15:0] ETHERTYPE = ETH_DEFAULT_ETHERTYPE
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        load_i,
  input  logic        beat_i,
  input  logic        tail_i,
  input  logic [31:0] in_data_i,
  input  logic [3:0]  in_keep_i,
  input  logic        in_last_i,
  output logic [31:0] data_o,
  output logic [3:0]  keep_o,
  output logic        last_o,
  output logic        need_tail_o
);

  logic [15:0] carry_q, carry_d;
  logic        wide_q, wide_d;
  logic [31:0] raw_s;

  // Carry and tail-width registers
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      carry_q <= 16'h0;
      wide_q  <= 1'b0;
    end else begin
      carry_q <= carry_d;
      wide_q  <= wide_d;
    end
  end

  // Carry holds the upper half of the previous beat (EtherType after the header)
  always_comb begin
    carry_d = carry_q;
    wide_d  = wide_q;
    if (load_i) begin
      carry_d = {ETHERTYPE[7:0], ETHERTYPE[15:8]};
    end else if (beat_i) begin
      carry_d = in_data_i[31:16];
      wide_d  = in_last_i ? in_keep_i[3] : wide_q;
    end else begin
      carry_d = carry_q;
    end
  end

  // Merged beat; bytes beyond keep are forced to zero
  always_comb begin
    keep_o      = 4'hF;
    last_o      = 1'b0;
    need_tail_o = 1'b0;
    raw_s       = {in_data_i[15:0], carry_q};
    if (tail_i) begin
      raw_s  = {16'h0, carry_q};
      keep_o = wide_q ? 4'h3 : 4'h1;
      last_o = 1'b1;
    end else if (in_last_i) begin
      case (in_keep_i)
        4'h1:    begin keep_o = 4'h7; last_o = 1'b1; end
        4'h3:    begin keep_o = 4'hF; last_o = 1'b1; end
        default: begin keep_o = 4'hF; need_tail_o = 1'b1; end
      endcase
    end else begin
      keep_o = 4'hF;
    end
    data_o = keep_mask(raw_s, keep_o);
  end

endmodule

// File: rtl/eth_frame_builder.sv
// Prepends the 14-byte Ethernet II header to each payload frame.
// Define ETH_FRAME_PAD_EN to zero-pad short frames to 60 bytes.
module eth_frame_builder
  import eth_frame_pkg::*;
#(
  parameter logic [47:0] SRC_MAC   = ETH_DEFAULT_SRC_MAC,
  parameter logic [15:0] ETHERTYPE = ETH_DEFAULT_ETHERTYPE
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [47:0]                s_hdr_dst_mac,
  input  logic                       s_hdr_valid,
  output logic                       s_hdr_ready,
  eth_frame_builder_if.slave         s_axis,
  eth_frame_builder_if.master        m_axis
);

  localparam logic [15:0] PAD_LAST_WORD = 16'(ETH_MIN_FRAME_WORDS - 1);

  state_e      state_q, state_d;
  logic [1:0]  hdr_cnt_q, hdr_cnt_d;
  logic [47:0] dst_q, dst_d;
  logic [15:0] word_cnt_q, word_cnt_d;

  logic        load_s, beat_s, tail_s;
  logic [31:0] sh_data_s, frm_data_s, m_data_s;
  logic [3:0]  sh_keep_s, frm_keep_s, m_keep_s;
  logic        sh_last_s, frm_last_s, m_last_s, need_tail_s;
  logic        pad_go_s, m_valid_s, s_ready_s;

  assign tail_s = (state_q == ST_TAIL);

  eth_tx_byte_shift #(.ETHERTYPE(ETHERTYPE)) u_shift (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .load_i      (load_s),
    .beat_i      (beat_s),
    .tail_i      (tail_s),
    .in_data_i   (s_axis.tdata),
    .in_keep_i   (s_axis.tkeep),
    .in_last_i   (s_axis.tlast),
    .data_o      (sh_data_s),
    .keep_o      (sh_keep_s),
    .last_o      (sh_last_s),
    .need_tail_o (need_tail_s)
  );

  // State and frame bookkeeping registers
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      hdr_cnt_q  <= 2'd0;
      dst_q      <= 48'h0;
      word_cnt_q <= 16'h0;
    end else begin
      state_q    <= state_d;
      hdr_cnt_q  <= hdr_cnt_d;
      dst_q      <= dst_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // A natural end before word 14 becomes a full beat and hands over to PAD
  always_comb begin
    frm_data_s = sh_data_s;
    frm_keep_s = sh_keep_s;
    frm_last_s = sh_last_s;
    pad_go_s   = 1'b0;
`ifdef ETH_FRAME_PAD_EN
    if (sh_last_s && (word_cnt_q < PAD_LAST_WORD)) begin
      frm_keep_s = 4'hF;
      frm_last_s = 1'b0;
      pad_go_s   = 1'b1;
    end else if (sh_last_s && (word_cnt_q == PAD_LAST_WORD)) begin
      frm_keep_s = 4'hF;
    end else begin
      frm_keep_s = sh_keep_s;
    end
`endif
  end

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    hdr_cnt_d   = hdr_cnt_q;
    dst_d       = dst_q;
    word_cnt_d  = word_cnt_q;
    s_hdr_ready = 1'b0;
    s_ready_s   = 1'b0;
    m_valid_s   = 1'b0;
    m_data_s    = 32'h0;
    m_keep_s    = 4'h0;
    m_last_s    = 1'b0;
    load_s      = 1'b0;
    beat_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        s_hdr_ready = 1'b1;
        word_cnt_d  = 16'h0;
        if (s_hdr_valid) begin
          dst_d     = s_hdr_dst_mac;
          hdr_cnt_d = 2'd0;
          state_d   = ST_HDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HDR: begin
        m_valid_s = 1'b1;
        m_keep_s  = 4'hF;
        m_data_s  = hdr_word(hdr_cnt_q, dst_q, SRC_MAC);
        if (m_axis.tready) begin
          word_cnt_d = word_cnt_q + 16'd1;
          hdr_cnt_d  = hdr_cnt_q + 2'd1;
          if (hdr_cnt_q == 2'd2) begin
            load_s  = 1'b1;
            state_d = ST_DATA;
          end else begin
            state_d = ST_HDR;
          end
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_DATA: begin
        m_valid_s = s_axis.tvalid;
        s_ready_s = m_axis.tready;
        m_data_s  = frm_data_s;
        m_keep_s  = frm_keep_s;
        m_last_s  = frm_last_s;
        if (s_axis.tvalid && m_axis.tready) begin
          beat_s     = 1'b1;
          word_cnt_d = word_cnt_q + 16'd1;
          if (!s_axis.tlast) begin
            state_d = ST_DATA;
          end else if (need_tail_s) begin
            state_d = ST_TAIL;
          end else begin
`ifdef ETH_FRAME_PAD_EN
            state_d = pad_go_s ? ST_PAD : ST_IDLE;
`else
            state_d = ST_IDLE;
`endif
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_TAIL: begin
        m_valid_s = 1'b1;
        m_data_s  = frm_data_s;
        m_keep_s  = frm_keep_s;
        m_last_s  = frm_last_s;
        if (m_axis.tready) begin
          word_cnt_d = word_cnt_q + 16'd1;
`ifdef ETH_FRAME_PAD_EN
          state_d = pad_go_s ? ST_PAD : ST_IDLE;
`else
          state_d = ST_IDLE;
`endif
        end else begin
          state_d = ST_TAIL;
        end
      end
`ifdef ETH_FRAME_PAD_EN
      ST_PAD: begin
        m_valid_s = 1'b1;
        m_keep_s  = 4'hF;
        m_last_s  = (word_cnt_q == PAD_LAST_WORD);
        if (m_axis.tready) begin
          word_cnt_d = word_cnt_q + 16'd1;
          state_d    = (word_cnt_q == PAD_LAST_WORD) ? ST_IDLE : ST_PAD;
        end else begin
          state_d = ST_PAD;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign s_axis.tready = s_ready_s;
  assign m_axis.tvalid = m_valid_s;
  assign m_axis.tdata  = m_data_s;
  assign m_axis.tkeep  = m_keep_s;
  assign m_axis.tlast  = m_last_s;

endmodule

// File: doc/eth_frame_builder.md
# eth_frame_builder

Prepends a 14-byte Ethernet II header (destination MAC, source MAC, EtherType) to each RDMA payload frame. It realigns the payload by 2 bytes onto the 32-bit AXI-Stream bus. It sits directly upstream of the Ethernet TX packet generator stage and feeds its data input.

## Interface
- SRC_MAC, 48'h00_0A_35_01_02_03, source MAC inserted in every frame
- ETHERTYPE, 16'h8915, EtherType inserted in every frame (RoCEv1)
- aclk  in  1  clock
- aresetn  in  1  reset: synchronous, active-low
- s_hdr_dst_mac  in  48  destination MAC for the next frame
- s_hdr_valid  in  1  header descriptor valid
- s_hdr_ready  out  1  header descriptor accepted
- s_axis_tdata  in  32  payload data; byte n of beat in bits [8n+7:8n]
- s_axis_tkeep  in  4  contiguous from lane 0; only the last beat may be partial (1,3,7,F)
- s_axis_tvalid / s_axis_tlast  in  1  payload valid / end of payload
- s_axis_tready  out  1  payload ready
- m_axis_tdata  out  32  frame data, same byte-lane order as the input
- m_axis_tkeep  out  4  frame byte enables
- m_axis_tvalid / m_axis_tlast  out  1  frame valid / end of frame
- m_axis_tready  in  1  downstream ready

## Operation
- Frame byte order: b0–b5 destination MAC, MSB first; b6–b11 SRC_MAC, MSB first; b12 = ETHERTYPE[15:8]; b13 = ETHERTYPE[7:0]; then the payload. Word k carries bytes 4k..4k+3, with byte 4k in [7:0].
- States: IDLE, HDR, DATA, TAIL, PAD (PAD exists only when padding is compiled in).
- IDLE:
  - s_hdr_ready=1, s_axis_tready=0, m_axis_tvalid=0.
  - On s_hdr_valid, latch the destination MAC, set hdr_cnt=0 and go to HDR.
- HDR:
  - Emit W0 (destination bytes 0–3), W1 (destination bytes 4–5, source bytes 0–1), W2 (source bytes 2–5).
  - tvalid=1, tkeep=F, tlast=0.
  - hdr_cnt advances on each handshake. After W2 is accepted, load carry={ETHERTYPE[7:0],ETHERTYPE[15:8]} and go to DATA.
- DATA:
  - m_axis_tdata={s_axis_tdata[15:0],carry}; m_axis_tvalid=s_axis_tvalid; s_axis_tready=m_axis_tready.
  - On each handshake, carry<=s_axis_tdata[31:16].
  - Last beat with tkeep 1 or 3: output tkeep 7 or F, tlast=1, go to IDLE.
  - Last beat with tkeep 7 or F: output tkeep F, tlast=0, go to TAIL.
- TAIL:
  - Emit {16'h0,carry} with tkeep 1 (input keep was 7) or 3 (input keep was F), tlast=1, s_axis_tready=0.
  - After the handshake, go to IDLE.
- A payload of zero beats is illegal. Every frame carries at least one payload byte.
- A 16-bit output word counter increments on every m_axis handshake and clears in IDLE.
- Reset mid-frame: return to IDLE immediately and discard the partial frame. Upstream must also reset.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tkeep=0, m_axis_tdata=0, s_axis_tready=0, s_hdr_ready=1.
- Header handshake in cycle N puts W0 valid in cycle N+1.
- Throughput is one beat per cycle while both sides are ready. There is exactly one idle (IDLE) cycle between frames.
- Outputs are combinational from the registered state in DATA. Otherwise they are driven from registers only.
- AXI-Stream rule: once m_axis_tvalid rises in HDR, TAIL or PAD, it holds with stable data until m_axis_tready. In DATA it follows s_axis_tvalid, which upstream must hold stable.
- Total output beats = ceil((14+P)/4), where P is the payload length in bytes. With padding enabled, the minimum is 15 beats.

## Configuration
- ETH_FRAME_PAD_EN defined:
  - Frames shorter than 60 bytes (14+P<60) are zero-padded to exactly 60 bytes, i.e. 15 beats with the last beat at tkeep F. The MAC appends the FCS.
  - The beat that would have carried tlast instead has tlast=0, tkeep=F and its unused bytes zeroed.
  - PAD then emits 32'h0 with tkeep F until word 14, which carries tlast=1.
- ETH_FRAME_PAD_EN undefined: no PAD state; frames end at their natural length, and the MAC is responsible for padding.

## Structure
- Package eth_frame_pkg: state enum, ETH_HDR_BYTES=14, ETH_MIN_FRAME_BYTES=60, ETH_MIN_FRAME_WORDS=15, default ETHERTYPE.
- Sub-module eth_tx_byte_shift: 16-bit carry register plus the merge/keep/last logic for DATA and TAIL. The FSM, header mux and pad counter stay in the top module.

## Test plan
- dst=AA_BB_CC_DD_EE_FF, payload 8 bytes (2 beats, keep F) -> W0=DDCCBBAA, W1=0A00FFEE, W2=03020135, W3={p1p0,1589}, W4 keep F, W5 keep 3, tlast on W5 (pad off).
- Payload 5 bytes (last keep 1) -> 5 output beats, final tkeep 7; with ETH_FRAME_PAD_EN -> 15 beats, words 5–14 zero-filled, tlast only on beat 14.
- Payload 64 bytes, m_axis_tready toggling 1010… -> no data loss or duplication, tvalid stable while stalled, 20 beats, last keep 3.
- Two back-to-back headers with payloads 46 and 47 bytes -> second header accepted one cycle after the first frame's tlast; 15 and 16 beats with pad on.
- aresetn low for 1 cycle during W3 -> all outputs at reset values next cycle; a new frame afterwards starts cleanly from W0.
